// File: rtl/alu_issue_stage.sv
// Purpose: ALU issue stage. Registers one operation, drives the external ALU and queues {W, Zero, Err, Tag} in a 2-entry in-order result FIFO.
// Latency: an op accepted on edge N is pushed on edge N+1, so OutValid is high in cycle N+2 when the FIFO was empty; 1 op/cycle sustained.
// Backpressure: InReady drops once two ops are in flight unless the head is popped this cycle; Out* hold stable while OutReady is low.
// Ports: CLK/Reset/Flush control; InValid/InReady/InA/InB/InCtrl/InTag upstream handshake; BusA/BusB/ALUCtrl to the ALU;
//        BusW/Zero back from the ALU; OutValid/OutReady/OutW/OutZero/OutErr/OutTag downstream handshake.
module alu_issue_stage (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Flush,
  input  logic        InValid,
  output logic        InReady,
  input  logic [63:0] InA,
  input  logic [63:0] InB,
  input  logic [3:0]  InCtrl,
  input  logic [4:0]  InTag,
  output logic [63:0] BusA,
  output logic [63:0] BusB,
  output logic [3:0]  ALUCtrl,
  input  logic [63:0] BusW,
  input  logic        Zero,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [63:0] OutW,
  output logic        OutZero,
  output logic        OutErr,
  output logic [4:0]  OutTag
);

  typedef struct packed {
    logic [63:0] w;
    logic        zero;
    logic        err;
    logic [4:0]  tag;
  } resEntry_t;

  logic                opValid;
  logic [4:0]          opTag;
  resEntry_t [1:0]     fifoMem;
  resEntry_t [1:0]     memNext;
  logic                wrPtr, rdPtr, wrPtrNext, rdPtrNext;
  logic [1:0]          count, countNext;
  logic [1:0]          occupancy;
  resEntry_t           head, headNext, pushEntry;
  logic                accept, push, pop, ctrlOk;

  assign occupancy = {1'b0, opValid} + count;
  assign OutValid  = (count != 2'd0);
  assign pop       = OutValid && OutReady;
  // A same-cycle pop frees a slot, so a full stage can still accept.
  assign InReady   = !Reset && !Flush && ((occupancy < 2'd2) || pop);
  assign accept    = InValid && InReady;
  // The operand register always drains into the FIFO on the next edge.
  assign push      = opValid;

  assign ctrlOk = (ALUCtrl == 4'd0) || (ALUCtrl == 4'd1) || (ALUCtrl == 4'd2) ||
                  (ALUCtrl == 4'd6) || (ALUCtrl == 4'd7);

  // Unsupported ops mask whatever the ALU produced so the result is clean.
  always_comb begin
    pushEntry.w    = ctrlOk ? BusW : 64'd0;
    pushEntry.zero = ctrlOk ? Zero : 1'b0;
    pushEntry.err  = !ctrlOk;
    pushEntry.tag  = opTag;
  end

  always_comb begin
    memNext   = fifoMem;
    wrPtrNext = wrPtr;
    rdPtrNext = rdPtr;
    countNext = count;
    if (push) begin
      memNext[wrPtr] = pushEntry;
      wrPtrNext      = ~wrPtr;
    end
    if (pop) begin
      rdPtrNext = ~rdPtr;
    end
    case ({push, pop})
      2'b10:   countNext = count + 2'd1;
      2'b01:   countNext = count - 2'd1;
      default: countNext = count;
    endcase
    // Out* are registered so they keep the last head once the FIFO empties.
    headNext = (countNext != 2'd0) ? memNext[rdPtrNext] : head;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      opValid <= 1'b0;
      opTag   <= '0;
      BusA    <= '0;
      BusB    <= '0;
      ALUCtrl <= '0;
      fifoMem <= '0;
      head    <= '0;
      wrPtr   <= 1'b0;
      rdPtr   <= 1'b0;
      count   <= 2'd0;
    end else if (Flush) begin
      // Operand buses and the visible head are left untouched.
      opValid <= 1'b0;
      wrPtr   <= 1'b0;
      rdPtr   <= 1'b0;
      count   <= 2'd0;
    end else begin
      opValid <= accept;
      if (accept) begin
        BusA    <= InA;
        BusB    <= InB;
        ALUCtrl <= InCtrl;
        opTag   <= InTag;
      end
      fifoMem <= memNext;
      wrPtr   <= wrPtrNext;
      rdPtr   <= rdPtrNext;
      count   <= countNext;
      head    <= headNext;
    end
  end

  assign OutW    = head.w;
  assign OutZero = head.zero;
  assign OutErr  = head.err;
  assign OutTag  = head.tag;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        Flush = 1'b0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [63:0] InA = '0;
  logic [63:0] InB = '0;
  logic [3:0]  InCtrl = '0;
  logic [4:0]  InTag = '0;
  logic [63:0] BusA, BusB, BusW;
  logic [3:0]  ALUCtrl;
  logic        Zero;
  logic        OutValid;
  logic        OutReady = 1'b0;
  logic [63:0] OutW;
  logic        OutZero, OutErr;
  logic [4:0]  OutTag;

  int passCnt = 0;
  int totalCnt = 0;

  alu_issue_stage dut (
    .CLK(CLK), .Reset(Reset), .Flush(Flush),
    .InValid(InValid), .InReady(InReady), .InA(InA), .InB(InB), .InCtrl(InCtrl), .InTag(InTag),
    .BusA(BusA), .BusB(BusB), .ALUCtrl(ALUCtrl), .BusW(BusW), .Zero(Zero),
    .OutValid(OutValid), .OutReady(OutReady), .OutW(OutW), .OutZero(OutZero), .OutErr(OutErr), .OutTag(OutTag)
  );

  always #5 CLK = ~CLK;

  // Behavioural ALU; garbage for unsupported codes so masking is observable.
  logic [63:0] aluW;
  logic        aluZ;
  always_comb begin
    aluW = 64'd0;
    aluZ = 1'b0;
    case (ALUCtrl)
      4'd0: aluW = BusA & BusB;
      4'd1: aluW = BusA | BusB;
      4'd2: aluW = BusA + BusB;
      4'd6: aluW = BusA - BusB;
      4'd7: aluW = BusB;
      default: aluW = 64'hDEAD_BEEF;
    endcase
    aluZ = (aluW == 64'd0);
    if (ALUCtrl == 4'd4) aluZ = 1'b1;
  end
  assign BusW = aluW;
  assign Zero = aluZ;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    totalCnt++; if (InReady !== 1'b0) $display("FAIL rst_inready got %b want 0", InReady); else passCnt++;
    totalCnt++; if (OutValid !== 1'b0) $display("FAIL rst_outvalid got %b want 0", OutValid); else passCnt++;
    totalCnt++; if (OutW !== 64'd0) $display("FAIL rst_outw got %h want 0", OutW); else passCnt++;
    totalCnt++; if (BusA !== 64'd0) $display("FAIL rst_busa got %h want 0", BusA); else passCnt++;
    Reset = 1'b0;
    #1;
    totalCnt++; if (InReady !== 1'b1) $display("FAIL rst_release_inready got %b want 1", InReady); else passCnt++;
  endtask

  task automatic test_add();
    OutReady = 1'b1;
    InValid = 1'b1; InA = 64'hACEB; InB = 64'hABDDE000; InCtrl = 4'd2; InTag = 5'd5;
    tick();
    InValid = 1'b0;
    totalCnt++; if (OutValid !== 1'b0) $display("FAIL add_early_valid got %b want 0", OutValid); else passCnt++;
    tick();
    totalCnt++; if (OutValid !== 1'b1) $display("FAIL add_valid got %b want 1", OutValid); else passCnt++;
    totalCnt++; if (OutW !== 64'hABDE8CEB) $display("FAIL add_w got %h want abde8ceb", OutW); else passCnt++;
    totalCnt++; if (OutZero !== 1'b0 || OutErr !== 1'b0) $display("FAIL add_flags got z%b e%b want z0 e0", OutZero, OutErr); else passCnt++;
    totalCnt++; if (OutTag !== 5'd5) $display("FAIL add_tag got %0d want 5", OutTag); else passCnt++;
    tick();
    totalCnt++; if (OutValid !== 1'b0) $display("FAIL add_drained got %b want 0", OutValid); else passCnt++;
    totalCnt++; if (OutW !== 64'hABDE8CEB) $display("FAIL add_hold_w got %h want abde8ceb", OutW); else passCnt++;
  endtask

  task automatic test_back_to_back();
    OutReady = 1'b1;
    InValid = 1'b1; InA = 64'h98760000; InB = 64'd0; InCtrl = 4'd0; InTag = 5'd1;
    tick();
    InA = 64'd0; InB = 64'h12ED; InCtrl = 4'd6; InTag = 5'd2;
    tick();
    InValid = 1'b0;
    totalCnt++; if (OutValid !== 1'b1 || OutW !== 64'd0 || OutZero !== 1'b1 || OutTag !== 5'd1)
      $display("FAIL b2b_and got v%b w%h z%b t%0d want v1 w0 z1 t1", OutValid, OutW, OutZero, OutTag); else passCnt++;
    tick();
    totalCnt++; if (OutValid !== 1'b1 || OutW !== 64'hFFFFFFFFFFFFED13 || OutZero !== 1'b0 || OutTag !== 5'd2)
      $display("FAIL b2b_sub got v%b w%h z%b t%0d want v1 w ffffffffffffed13 z0 t2", OutValid, OutW, OutZero, OutTag); else passCnt++;
    tick();
    totalCnt++; if (OutValid !== 1'b0) $display("FAIL b2b_drained got %b want 0", OutValid); else passCnt++;
    totalCnt++; if (ALUCtrl !== 4'd6 || BusB !== 64'h12ED) $display("FAIL b2b_bus_hold got c%0d b%h want c6 b12ed", ALUCtrl, BusB); else passCnt++;
  endtask

  task automatic test_backpressure();
    int acc = 0;
    OutReady = 1'b0;
    InValid = 1'b1; InCtrl = 4'd2;
    InA = 64'(acc * 2 + 1); InB = 64'(acc * 2 + 2); InTag = 5'(acc + 1);
    for (int i = 0; i < 4; i++) begin
      if (InReady) acc++;
      tick();
      InA = 64'(acc * 2 + 1); InB = 64'(acc * 2 + 2); InTag = 5'(acc + 1);
    end
    totalCnt++; if (acc !== 2) $display("FAIL bp_accepted got %0d want 2", acc); else passCnt++;
    totalCnt++; if (InReady !== 1'b0) $display("FAIL bp_inready got %b want 0", InReady); else passCnt++;
    totalCnt++; if (OutValid !== 1'b1 || OutW !== 64'd3 || OutTag !== 5'd1)
      $display("FAIL bp_head_stable got v%b w%h t%0d want v1 w3 t1", OutValid, OutW, OutTag); else passCnt++;
    OutReady = 1'b1;
    #1;
    totalCnt++; if (InReady !== 1'b1) $display("FAIL bp_ready_on_pop got %b want 1", InReady); else passCnt++;
    tick();
    InValid = 1'b0;
    totalCnt++; if (OutValid !== 1'b1 || OutW !== 64'd7 || OutTag !== 5'd2)
      $display("FAIL bp_second got v%b w%h t%0d want v1 w7 t2", OutValid, OutW, OutTag); else passCnt++;
    tick();
    totalCnt++; if (OutValid !== 1'b1 || OutW !== 64'd11 || OutTag !== 5'd3)
      $display("FAIL bp_third got v%b w%h t%0d want v1 wb t3", OutValid, OutW, OutTag); else passCnt++;
    tick();
    totalCnt++; if (OutValid !== 1'b0) $display("FAIL bp_drained got %b want 0", OutValid); else passCnt++;
  endtask

  task automatic test_err();
    OutReady = 1'b1;
    InValid = 1'b1; InA = 64'd5; InB = 64'd7; InCtrl = 4'd4; InTag = 5'd31;
    tick();
    InValid = 1'b0;
    tick();
    totalCnt++; if (OutValid !== 1'b1 || OutErr !== 1'b1) $display("FAIL err_flag got v%b e%b want v1 e1", OutValid, OutErr); else passCnt++;
    totalCnt++; if (OutW !== 64'd0 || OutZero !== 1'b0) $display("FAIL err_mask got w%h z%b want w0 z0", OutW, OutZero); else passCnt++;
    totalCnt++; if (OutTag !== 5'd31) $display("FAIL err_tag got %0d want 31", OutTag); else passCnt++;
    tick();
  endtask

  task automatic test_flush();
    OutReady = 1'b0;
    InValid = 1'b1; InA = 64'd1; InB = 64'd1; InCtrl = 4'd0; InTag = 5'd10;
    tick();
    InA = 64'd2; InB = 64'd2; InCtrl = 4'd1; InTag = 5'd11;
    tick();
    InA = 64'd40; InB = 64'd2; InCtrl = 4'd2; InTag = 5'd12;
    Flush = 1'b1;
    #1;
    totalCnt++; if (InReady !== 1'b0) $display("FAIL flush_inready got %b want 0", InReady); else passCnt++;
    tick();
    Flush = 1'b0;
    #1;
    totalCnt++; if (OutValid !== 1'b0) $display("FAIL flush_outvalid got %b want 0", OutValid); else passCnt++;
    totalCnt++; if (InReady !== 1'b1) $display("FAIL flush_ready_after got %b want 1", InReady); else passCnt++;
    totalCnt++; if (BusA !== 64'd2 || ALUCtrl !== 4'd1) $display("FAIL flush_bus_hold got a%h c%0d want a2 c1", BusA, ALUCtrl); else passCnt++;
    tick();
    InValid = 1'b0;
    tick();
    totalCnt++; if (OutValid !== 1'b1 || OutW !== 64'h2A || OutTag !== 5'd12)
      $display("FAIL flush_next_op got v%b w%h t%0d want v1 w2a t12", OutValid, OutW, OutTag); else passCnt++;
    OutReady = 1'b1;
    tick();
  endtask

  task automatic test_reset_full();
    OutReady = 1'b0;
    InValid = 1'b1; InA = 64'd1; InB = 64'd1; InCtrl = 4'd2; InTag = 5'd3;
    tick();
    tick();
    InValid = 1'b0;
    tick();
    totalCnt++; if (OutValid !== 1'b1 || OutW !== 64'd2) $display("FAIL rf_filled got v%b w%h want v1 w2", OutValid, OutW); else passCnt++;
    Reset = 1'b1;
    #1;
    totalCnt++; if (InReady !== 1'b0) $display("FAIL rf_inready_during got %b want 0", InReady); else passCnt++;
    tick();
    totalCnt++; if (OutValid !== 1'b0 || OutW !== 64'd0 || OutTag !== 5'd0 || OutErr !== 1'b0 || OutZero !== 1'b0)
      $display("FAIL rf_outputs got v%b w%h t%0d e%b z%b want all 0", OutValid, OutW, OutTag, OutErr, OutZero); else passCnt++;
    totalCnt++; if (BusA !== 64'd0 || BusB !== 64'd0 || ALUCtrl !== 4'd0)
      $display("FAIL rf_buses got a%h b%h c%0d want all 0", BusA, BusB, ALUCtrl); else passCnt++;
    Reset = 1'b0;
    #1;
    totalCnt++; if (InReady !== 1'b1) $display("FAIL rf_inready_after got %b want 1", InReady); else passCnt++;
    OutReady = 1'b1;
    tick();
    tick();
    totalCnt++; if (OutValid !== 1'b0) $display("FAIL rf_no_ghost got %b want 0", OutValid); else passCnt++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_backpressure();
    test_err();
    test_flush();
    test_reset_full();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have no parameters; all widths fixed: data 64, ALUCtrl 4, tag 5.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports, one per line (name  direction  width  meaning):
- CLK  in  1  clock, all state on rising edge
- Reset  in  1  synchronous active-high reset
- Flush  in  1  synchronous discard of all in-flight work
- InValid  in  1  upstream operation offered
- InReady  out  1  stage accepts operation this edge
- InA  in  64  operand A
- InB  in  64  operand B
- InCtrl  in  4  ALU op: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 PASSB
- InTag  in  5  destination register tag, carried unmodified
- BusA  out  64  to ALU BusA
- BusB  out  64  to ALU BusB
- ALUCtrl  out  4  to ALU ALUCtrl
- BusW  in  64  ALU result, combinational from BusA/BusB/ALUCtrl
- Zero  in  1  ALU zero flag
- OutValid  out  1  result available
- OutReady  in  1  downstream takes result this edge
- OutW  out  64  result
- OutZero  out  1  zero flag of result
- OutErr  out  1  op code unsupported
- OutTag  out  5  tag of result

Function
REQ-004 Structure: one operand register (OpValid, A, B, Ctrl, Tag) driving BusA/BusB/ALUCtrl, followed by a 2-entry result FIFO {W, Zero, Err, Tag}.
REQ-005 Accept = InValid && InReady at rising edge; accepted fields load operand register.
REQ-006 Occupancy = OpValid + FIFO count (0..2); InReady = !Reset && !Flush && (Occupancy < 2 || (OutValid && OutReady)).
REQ-007 InReady SHALL depend combinationally on OutReady/OutValid only via REQ-006; no path from InValid to InReady.
REQ-008 When OpValid, next edge SHALL push {BusW, Zero, Err, Tag} into FIFO; space is guaranteed by REQ-006, overflow never occurs.
REQ-009 Latency: operation accepted on edge N appears on Out* after edge N+1 (OutValid high in cycle N+2) when FIFO was empty; throughput 1 op/cycle with OutReady held high.
REQ-010 OutValid = FIFO non-empty; Out* show FIFO head; pop on OutValid && OutReady; Out* SHALL hold stable while OutValid && !OutReady.
REQ-011 Push and pop on same edge SHALL leave count unchanged, order preserved (FIFO strict in-order).
REQ-012 Unsupported InCtrl (not 0,1,2,6,7): operation still accepted and tag delivered; result entry SHALL have OutErr=1, OutW=0, OutZero=0.
REQ-013 BusA/BusB/ALUCtrl SHALL hold last loaded values when OpValid=0.
REQ-014 Flush: at edge, OpValid and FIFO count cleared; concurrent input not accepted (InReady=0); concurrent pop discarded; BusA/BusB/ALUCtrl hold values.
REQ-015 Empty FIFO: OutValid=0, OutReady ignored; Out* hold last head values.
REQ-016 FIFO pointers 1-bit, wrap modulo 2.

Reset
REQ-017 Reset at edge SHALL clear OpValid, FIFO count and pointers, BusA, BusB, ALUCtrl, OutW, OutZero, OutErr, OutTag to 0; OutValid=0.
REQ-018 InReady=0 while Reset high; InReady=1 in first cycle after Reset deasserted.
REQ-019 Reset mid-operation SHALL drop all in-flight operations; none appear on Out*; Reset has priority over Flush.

Verification
REQ-020 ADD: InA=0xACEB, InB=0xABDDE000, InCtrl=2, InTag=5, OutReady=1 -> OutValid in cycle N+2, OutW=0xABDE8CEB, OutZero=0, OutErr=0, OutTag=5.
REQ-021 Back-to-back AND 0x98760000,0 then SUB 0,0x12ED -> consecutive cycles: {OutW=0, OutZero=1}, then {OutW=0xFFFFFFFFFFFFED13, OutZero=0}; order kept.
REQ-022 Backpressure: OutReady=0, InValid=1 continuously -> exactly 2 accepted, InReady=0 thereafter, Out* stable; OutReady=1 -> both drained in order, InReady high the same cycle as first pop.
REQ-023 InCtrl=4, InTag=31 -> OutErr=1, OutW=0, OutZero=0, OutTag=31.
REQ-024 Flush with 2 in flight and InValid=1 -> OutValid=0 next cycle, new input not accepted that edge, accepted next edge.
REQ-025 Reset asserted with FIFO full -> all outputs 0, OutValid=0, InReady=0 during reset, 1 after.
